// File: rtl/mem_wb_stage_pkg.sv
// rtl/mem_wb_stage_pkg.sv - shared state encoding and defaults for the MEM/WB stage
package mem_wb_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_HALTED = 2'd2
    } wb_state_t;

    localparam int TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/mem_wb_stage_if.sv
// rtl/mem_wb_stage_if.sv - data-memory request/response bus between MEM/WB stage and memory
interface mem_wb_stage_if;

    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_ready;
    logic [15:0] mem_rdata;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_ready, mem_rdata
    );

endinterface

// File: rtl/dff.sv
// rtl/dff.sv - generic register cell with synchronous reset and write enable
module dff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/mem_wb_stage_load_align.sv
// rtl/mem_wb_stage_load_align.sv - word/byte load selection with zero extension
module mem_wb_stage_load_align (
    input  logic [15:0] rdata,
    input  logic        load_byte,
    input  logic        byte_sel,
    output logic [15:0] data
);

    always_comb begin
        data = rdata;
        if (load_byte) begin
            data = byte_sel ? {8'h00, rdata[15:8]} : {8'h00, rdata[7:0]};
        end
    end

endmodule

// File: rtl/mem_wb_stage.sv
// rtl/mem_wb_stage.sv - MEM/WB stage: data-memory handshake, timeout, halt and W register
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [3:0]            M_Destination,
    input  logic [15:0]           M_ALUout,
    input  logic [15:0]           M_WriteData,
    input  logic [15:0]           M_Nxt_Pc,
    input  logic                  M_hlt,
    input  logic                  M_MemtoReg,
    input  logic                  M_MemRead,
    input  logic                  M_MemWrite,
    input  logic                  M_RegWrite,
    input  logic                  M_Pcs,
    input  logic                  M_load_byte,
    mem_wb_stage_if.master        mem,
    output logic                  stall,
    output logic [3:0]            W_Destination,
    output logic [15:0]           W_Result,
    output logic                  W_RegWrite,
    output logic                  W_hlt,
    output logic                  mem_err
);

    wb_state_t   state;
    wb_state_t   state_next;
    logic [3:0]  wait_cnt;
    logic        err_q;
    logic        mem_op;
    logic        timeout_now;
    logic [15:0] load_data;
    logic [15:0] result_next;

    assign mem_op        = M_MemRead | M_MemWrite;
    assign mem.mem_addr  = M_ALUout;
    assign mem.mem_wdata = M_WriteData;
    assign mem.mem_wr    = M_MemWrite;

    // The IDLE request cycle is the first wait, so ACCESS gives up one count early.
    always_comb begin
        state_next  = state;
        mem.mem_req = 1'b0;
        timeout_now = 1'b0;
        case (state)
            ST_IDLE: begin
                if (mem_op) begin
                    mem.mem_req = 1'b1;
                    if (!mem.mem_ready) begin
                        state_next = ST_ACCESS;
                    end else if (M_hlt) begin
                        state_next = ST_HALTED;
                    end
                end else if (M_hlt) begin
                    state_next = ST_HALTED;
                end
            end
            ST_ACCESS: begin
                if (wait_cnt == 4'(TIMEOUT - 1)) begin
                    timeout_now = 1'b1;
                    state_next  = M_hlt ? ST_HALTED : ST_IDLE;
                end else begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        state_next = M_hlt ? ST_HALTED : ST_IDLE;
                    end
                end
            end
            ST_HALTED: begin
                state_next = ST_HALTED;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign stall   = (mem.mem_req & ~mem.mem_ready) | (state == ST_HALTED);
    assign mem_err = err_q | timeout_now;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_IDLE && state_next == ST_ACCESS) begin
                wait_cnt <= 4'd0;
            end else if (state == ST_ACCESS && !mem.mem_ready && wait_cnt != 4'hF) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (timeout_now) begin
                err_q <= 1'b1;
            end
        end
    end

    mem_wb_stage_load_align u_load_align (
        .rdata     (mem.mem_rdata),
        .load_byte (M_load_byte),
        .byte_sel  (M_ALUout[0]),
        .data      (load_data)
    );

    assign result_next = M_Pcs ? M_Nxt_Pc : (M_MemtoReg ? load_data : M_ALUout);

    dff #(.WIDTH(4)) u_w_dest (
        .clk (clk), .rst (rst), .wen (~stall), .d (M_Destination), .q (W_Destination)
    );

    dff #(.WIDTH(16)) u_w_result (
        .clk (clk), .rst (rst), .wen (~stall), .d (result_next), .q (W_Result)
    );

    // A halt or timed-out instruction retires without writing the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            W_RegWrite <= 1'b0;
            W_hlt      <= 1'b0;
        end else if (state == ST_HALTED) begin
            W_RegWrite <= 1'b0;
        end else if (stall) begin
            W_RegWrite <= 1'b0;
            W_hlt      <= 1'b0;
        end else begin
            W_RegWrite <= M_RegWrite & ~timeout_now & ~M_hlt;
            W_hlt      <= M_hlt;
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// tb/tb_mem_wb_stage.sv - scoreboard bench for mem_wb_stage with randomized instruction stream
module tb_mem_wb_stage;

    localparam int TO = 15;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] alu;
        logic [15:0] wdata;
        logic [15:0] npc;
        logic        hlt, m2r, rd, wr, rw, pcs, lb;
    } instr_t;

    typedef struct {
        logic [3:0]  dest;
        logic [15:0] result;
        logic        rw;
        logic        hlt;
        logic        to;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  M_Destination;
    logic [15:0] M_ALUout, M_WriteData, M_Nxt_Pc;
    logic        M_hlt, M_MemtoReg, M_MemRead, M_MemWrite, M_RegWrite, M_Pcs, M_load_byte;
    logic        stall, W_RegWrite, W_hlt, mem_err;
    logic [3:0]  W_Destination;
    logic [15:0] W_Result;

    mem_wb_stage_if mem_bus ();

    mem_wb_stage dut (
        .clk (clk), .rst (rst),
        .M_Destination (M_Destination), .M_ALUout (M_ALUout), .M_WriteData (M_WriteData),
        .M_Nxt_Pc (M_Nxt_Pc), .M_hlt (M_hlt), .M_MemtoReg (M_MemtoReg), .M_MemRead (M_MemRead),
        .M_MemWrite (M_MemWrite), .M_RegWrite (M_RegWrite), .M_Pcs (M_Pcs),
        .M_load_byte (M_load_byte), .mem (mem_bus), .stall (stall),
        .W_Destination (W_Destination), .W_Result (W_Result), .W_RegWrite (W_RegWrite),
        .W_hlt (W_hlt), .mem_err (mem_err)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_fails  = 0;
    exp_t sb[$];
    bit   mon_en   = 1'b0;
    bit   prev_adv = 1'b0;
    bit   err_model = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic instr_t nop_instr();
        instr_t i;
        i.dest = 4'd0; i.alu = 16'd0; i.wdata = 16'd0; i.npc = 16'd0;
        i.hlt = 1'b0; i.m2r = 1'b0; i.rd = 1'b0; i.wr = 1'b0;
        i.rw = 1'b0; i.pcs = 1'b0; i.lb = 1'b0;
        return i;
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        int kind;
        i = nop_instr();
        kind = $urandom_range(0, 4);
        i.dest = 4'($urandom); i.alu = 16'($urandom);
        i.wdata = 16'($urandom); i.npc = 16'($urandom);
        case (kind)
            0: i.rw = 1'($urandom);
            1, 2: begin i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.lb = (kind == 2); end
            3: i.wr = 1'b1;
            default: begin i.pcs = 1'b1; i.rw = 1'b1; i.m2r = 1'($urandom); end
        endcase
        return i;
    endfunction

    task automatic drive(input instr_t i);
        M_Destination = i.dest; M_ALUout = i.alu; M_WriteData = i.wdata; M_Nxt_Pc = i.npc;
        M_hlt = i.hlt; M_MemtoReg = i.m2r; M_MemRead = i.rd; M_MemWrite = i.wr;
        M_RegWrite = i.rw; M_Pcs = i.pcs; M_load_byte = i.lb;
    endtask

    // Present one instruction until it leaves the stage; memory answers after lat cycles.
    task automatic issue(input instr_t i, input int lat, input logic [15:0] rdata, output int nreq);
        exp_t        e;
        logic        memop;
        logic [15:0] ld;
        int          cyc, nstall, exp_stall;
        bit          done;
        @(posedge clk); #1;
        drive(i);
        mon_en = 1'b1;
        memop = i.rd | i.wr;
        if (!i.lb)        ld = rdata;
        else if (i.alu[0]) ld = rdata >> 8;
        else              ld = rdata & 16'h00FF;
        e.to     = memop && (lat >= TO);
        e.rw     = i.rw && !e.to && !i.hlt;
        e.hlt    = i.hlt;
        e.dest   = i.dest;
        e.result = i.pcs ? i.npc : (i.m2r ? ld : i.alu);
        sb.push_back(e);
        exp_stall = !memop ? 0 : ((lat >= TO) ? TO : lat);
        cyc = 0; nstall = 0; nreq = 0; done = 1'b0;
        while (!done) begin
            mem_bus.mem_rdata = rdata;
            mem_bus.mem_ready = memop ? (cyc >= lat) : 1'($urandom_range(0, 1));
            @(negedge clk);
            check("mem_req", mem_bus.mem_req, memop && (cyc < TO));
            if (mem_bus.mem_req) begin
                nreq++;
                check("mem_addr", mem_bus.mem_addr, i.alu);
                check("mem_wdata", mem_bus.mem_wdata, i.wdata);
                check("mem_wr", mem_bus.mem_wr, i.wr);
            end
            if (stall) begin
                nstall++;
                if (cyc > 0) check("W_RegWrite_bubble", W_RegWrite, 1'b0);
            end
            if (!stall) begin
                done = 1'b1;
            end else if (cyc >= 40) begin
                n_checks++; n_fails++;
                $display("FAIL issue_bound: stall still 1 after %0d cycles, required 0", cyc);
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        check("stall_cycles", nstall, exp_stall);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        drive(nop_instr());
        @(negedge clk); #1;
        mon_en = 1'b0;
        @(negedge clk); #1;
    endtask

    // Monitor: an instruction that advanced (stall low) appears in W one cycle later.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en && prev_adv) begin
                if (sb.size() == 0) begin
                    n_checks++; n_fails++;
                    $display("FAIL sb_underflow: W advanced with no expected entry, required an entry");
                end else begin
                    e = sb.pop_front();
                    err_model = err_model | e.to;
                    check("W_RegWrite", W_RegWrite, e.rw);
                    check("W_hlt", W_hlt, e.hlt);
                    check("mem_err", mem_err, err_model);
                    if (!e.to) begin
                        check("W_Destination", W_Destination, e.dest);
                        check("W_Result", W_Result, e.result);
                    end
                end
            end
            prev_adv = mon_en && !rst && !stall;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        instr_t i;
        int     nreq;
        rst = 1'b1;
        drive(nop_instr());
        mem_bus.mem_ready = 1'b0;
        mem_bus.mem_rdata = 16'h0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_W_RegWrite", W_RegWrite, 1'b0);
        check("rst_W_hlt", W_hlt, 1'b0);
        check("rst_W_Result", W_Result, 16'h0);
        check("rst_W_Destination", W_Destination, 4'h0);
        check("rst_mem_err", mem_err, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        i = nop_instr(); i.alu = 16'h1234; i.rw = 1'b1; i.dest = 4'd3;
        issue(i, 0, 16'h0000, nreq);
        i = nop_instr(); i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.dest = 4'd5; i.alu = 16'h0040;
        issue(i, 3, 16'hBEEF, nreq);
        i = nop_instr(); i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.lb = 1'b1;
        i.dest = 4'd7; i.alu = 16'h0011;
        issue(i, 0, 16'hAB12, nreq);

        for (int k = 0; k < 60; k++) begin
            int lat;
            lat = ($urandom_range(0, 7) == 0) ? TO + $urandom_range(0, 2) : $urandom_range(0, 4);
            issue(rand_instr(), lat, 16'($urandom), nreq);
        end

        i = nop_instr(); i.wr = 1'b1; i.alu = 16'h0200; i.wdata = 16'h5A5A;
        issue(i, 1000, 16'h0000, nreq);
        check("timeout_req_cycles", nreq, TO);
        check("timeout_mem_err", mem_err, 1'b1);
        check("timeout_mem_req", mem_bus.mem_req, 1'b0);
        check("timeout_stall", stall, 1'b0);

        for (int k = 0; k < 10; k++) begin
            issue(rand_instr(), $urandom_range(0, 3), 16'($urandom), nreq);
        end

        i = nop_instr(); i.hlt = 1'b1; i.rw = 1'b1; i.dest = 4'd9; i.alu = 16'h0F0F;
        issue(i, 0, 16'h0000, nreq);
        drain();
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            i = nop_instr(); i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.alu = 16'($urandom);
            drive(i);
            mem_bus.mem_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("halt_mem_req", mem_bus.mem_req, 1'b0);
            check("halt_stall", stall, 1'b1);
            check("halt_W_hlt", W_hlt, 1'b1);
            check("halt_W_RegWrite", W_RegWrite, 1'b0);
        end

        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(nop_instr());
        err_model = 1'b0;
        @(negedge clk);
        check("hrst_W_hlt", W_hlt, 1'b0);
        check("hrst_W_RegWrite", W_RegWrite, 1'b0);
        check("hrst_W_Result", W_Result, 16'h0);
        check("hrst_W_Destination", W_Destination, 4'h0);
        check("hrst_mem_err", mem_err, 1'b0);
        check("hrst_stall", stall, 1'b0);
        check("hrst_mem_req", mem_bus.mem_req, 1'b0);

        @(posedge clk); #1;
        i = nop_instr(); i.rd = 1'b1; i.m2r = 1'b1; i.rw = 1'b1; i.dest = 4'd4; i.alu = 16'h0100;
        drive(i);
        mem_bus.mem_ready = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        @(negedge clk);
        check("abort_pre_mem_req", mem_bus.mem_req, 1'b1);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(nop_instr());
        @(negedge clk);
        check("abort_mem_req", mem_bus.mem_req, 1'b0);
        check("abort_stall", stall, 1'b0);
        check("abort_W_RegWrite", W_RegWrite, 1'b0);

        i = nop_instr(); i.alu = 16'h4321; i.rw = 1'b1; i.dest = 4'd2;
        issue(i, 0, 16'h0000, nreq);
        drain();
        check("scoreboard_empty", sb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
